// File: rtl/decoder_strobe_if.sv
// decoder_strobe_if: code handshake and strobe outputs of the 3-to-8 strobe decoder.
// Optional macro DECODER_STROBE_PARITY_EN adds the par input and perr output.
interface decoder_strobe_if;
    logic       a;
    logic       b;
    logic       c;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] d;
    logic       strobe;
    logic       busy;
`ifdef DECODER_STROBE_PARITY_EN
    logic       par;
    logic       perr;

    modport master (output a, b, c, in_valid, par,
                    input  in_ready, d, strobe, busy, perr);
    modport slave  (input  a, b, c, in_valid, par,
                    output in_ready, d, strobe, busy, perr);
`else
    modport master (output a, b, c, in_valid,
                    input  in_ready, d, strobe, busy);
    modport slave  (input  a, b, c, in_valid,
                    output in_ready, d, strobe, busy);
`endif
endinterface

// File: rtl/decoder_strobe.sv
// decoder_strobe: sequential 3-to-8 decoder. Each accepted code {a,b,c} drives
// its one-hot d line for HOLD_CYCLES cycles followed by GAP_CYCLES zero cycles.
// A one-entry buffer queues the next code while a strobe is in progress.
// Optional macro DECODER_STROBE_PARITY_EN: even-parity check on {a,b,c,par};
// a bad code is consumed, not decoded, and pulses perr for one cycle.
module decoder_strobe #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic            clk,
    input  logic            rst,
    decoder_strobe_if.slave bus
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [0:7]    d_reg, d_next;
    logic          strobe_reg;
    logic          buf_full_reg, buf_full_next;
    logic [2:0]    buf_code_reg, buf_code_next;

    logic [2:0]    code_in;
    logic [0:7]    onehot_in;
    logic [0:7]    onehot_buf;
    logic          par_ok;
    logic          xfer;
    logic          take;
    logic          select_next_code;
    logic          stash;

    assign code_in = {bus.a, bus.b, bus.c};
    assign xfer    = bus.in_valid && !buf_full_reg;
    assign take    = xfer && par_ok;

    // One-hot images of the incoming code and the buffered code.
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_dec
        assign onehot_in[gi]  = (code_in == 3'(gi));
        assign onehot_buf[gi] = (buf_code_reg == 3'(gi));
    end

`ifdef DECODER_STROBE_PARITY_EN
    logic perr_reg;

    assign par_ok   = ~^{bus.a, bus.b, bus.c, bus.par};
    assign bus.perr = perr_reg;

    // One-cycle parity-error pulse for a consumed but rejected code.
    always_ff @(posedge clk) begin
        if (rst) perr_reg <= 1'b0;
        else     perr_reg <= xfer && !par_ok;
    end
`else
    assign par_ok = 1'b1;
`endif

    // Next-state logic: hold/gap counting, buffering, and next-code selection.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        d_next           = d_reg;
        buf_full_next    = buf_full_reg;
        buf_code_next    = buf_code_reg;
        select_next_code = 1'b0;
        stash            = 1'b0;
        case (state_reg)
            IDLE: begin
                // The buffer is empty in IDLE, so a new code goes straight to d.
                if (take) begin
                    d_next     = onehot_in;
                    cnt_next   = HOLD_LOAD;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                    stash    = take;
                end else if (GAP_CYCLES > 0) begin
                    d_next     = '0;
                    cnt_next   = GAP_LOAD;
                    state_next = GAP;
                    stash      = take;
                end else begin
                    select_next_code = 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                    stash    = take;
                end else begin
                    select_next_code = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                d_next     = '0;
                cnt_next   = '0;
            end
        endcase

        // Buffered code has priority; in_ready is low while it is held, so
        // no direct transfer can collide with a pop.
        if (select_next_code) begin
            if (buf_full_reg) begin
                d_next        = onehot_buf;
                cnt_next      = HOLD_LOAD;
                state_next    = DRIVE;
                buf_full_next = 1'b0;
            end else if (take) begin
                d_next     = onehot_in;
                cnt_next   = HOLD_LOAD;
                state_next = DRIVE;
            end else begin
                d_next     = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        end

        if (stash) begin
            buf_full_next = 1'b1;
            buf_code_next = code_in;
        end
    end

    // State register; reset cuts the strobe and drops any buffered code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            d_reg        <= '0;
            strobe_reg   <= 1'b0;
            buf_full_reg <= 1'b0;
            buf_code_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            d_reg        <= d_next;
            strobe_reg   <= |d_next;
            buf_full_reg <= buf_full_next;
            buf_code_reg <= buf_code_next;
        end
    end

    assign bus.d        = d_reg;
    assign bus.strobe   = strobe_reg;
    assign bus.in_ready = !buf_full_reg;
    assign bus.busy     = (state_reg != IDLE) || buf_full_reg;
endmodule

// File: tb/tb_decoder_strobe.sv
// tb_decoder_strobe: two decoder instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked every cycle against a schedule model: each accepted code starts at
// max(accept edge, previous start + period) and is pending until it starts.
module tb_decoder_strobe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder_strobe_if if0();
    decoder_strobe_if if1();

    decoder_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    decoder_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic       vld     [2];
    logic [2:0] code    [2];
    logic       par_bad [2];

    assign if0.in_valid = vld[0];
    assign {if0.a, if0.b, if0.c} = code[0];
    assign if1.in_valid = vld[1];
    assign {if1.a, if1.b, if1.c} = code[1];
`ifdef DECODER_STROBE_PARITY_EN
    assign if0.par = (^code[0]) ^ par_bad[0];
    assign if1.par = (^code[1]) ^ par_bad[1];
`endif

    // Reference schedule
    int hold_c [2] = '{4, 1};
    int period [2] = '{5, 1};
    int e_code  [2][4];
    int e_start [2][4];
    int e_acc   [2][4];
    bit e_valid [2][4];
    int wp         [2];
    int last_start [2];
    int perr_edge  [2];
    bit acc_last   [2];

    int cyc;
    int n_checks;
    int n_fails;

    function automatic bit m_pending(int i, int n);
        for (int k = 0; k < 4; k++)
            if (e_valid[i][k] && e_acc[i][k] <= n && n < e_start[i][k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(int i, int n);
        for (int k = 0; k < 4; k++)
            if (e_valid[i][k] && e_start[i][k] <= n && n < e_start[i][k] + period[i]) return 1'b1;
        return m_pending(i, n);
    endfunction

    function automatic logic [0:7] m_d(int i, int n);
        logic [0:7] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (e_valid[i][k] && e_start[i][k] <= n && n < e_start[i][k] + hold_c[i])
                r[e_code[i][k]] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) e_valid[i][k] = 1'b0;
            wp[i]         = 0;
            last_start[i] = -1000;
            perr_edge[i]  = -1000;
        end
    endtask

    task automatic m_accept(int i, int e);
        int s;
        if (par_bad[i]) begin
            perr_edge[i] = e;
            $display("xfer dut%0d edge=%0d code=%0d rejected(parity)", i, e, code[i]);
        end else begin
            s = (e > last_start[i] + period[i]) ? e : last_start[i] + period[i];
            e_code[i][wp[i]]  = int'(code[i]);
            e_start[i][wp[i]] = s;
            e_acc[i][wp[i]]   = e;
            e_valid[i][wp[i]] = 1'b1;
            wp[i]             = (wp[i] + 1) % 4;
            last_start[i]     = s;
            $display("xfer dut%0d edge=%0d code=%0d strobe_start=%0d", i, e, code[i], s);
        end
    endtask

    task automatic check(string tag, int i, logic [7:0] obs, logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(int i, logic [0:7] d_o, logic s_o, logic b_o, logic r_o);
        logic [0:7] ed;
        ed = m_d(i, cyc);
        check("d", i, d_o, ed);
        check("strobe", i, {7'b0, s_o}, {7'b0, |ed});
        check("busy", i, {7'b0, b_o}, {7'b0, m_busy(i, cyc)});
        check("in_ready", i, {7'b0, r_o}, {7'b0, !m_pending(i, cyc)});
    endtask

    // One clock: sample model readiness, take the edge, update model, check.
    task automatic step(input logic r);
        bit rdy [2];
        for (int i = 0; i < 2; i++) rdy[i] = !m_pending(i, cyc);
        rst = r;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) acc_last[i] = 1'b0;
        if (r) begin
            m_reset();
        end else begin
            for (int i = 0; i < 2; i++)
                if (vld[i] && rdy[i]) begin
                    acc_last[i] = 1'b1;
                    m_accept(i, cyc);
                end
        end
        #1;
        check_dut(0, if0.d, if0.strobe, if0.busy, if0.in_ready);
        check_dut(1, if1.d, if1.strobe, if1.busy, if1.in_ready);
`ifdef DECODER_STROBE_PARITY_EN
        check("perr", 0, {7'b0, if0.perr}, {7'b0, perr_edge[0] == cyc});
        check("perr", 1, {7'b0, if1.perr}, {7'b0, perr_edge[1] == cyc});
`endif
    endtask

    task automatic idle(int n);
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        for (int t = 0; t < n; t++) step(1'b0);
    endtask

    // Present a code on one instance and hold it until accepted.
    task automatic send(int i, int cd, bit bad);
        vld[i]     = 1'b1;
        code[i]    = 3'(cd);
        par_bad[i] = bad;
        for (int t = 0; t < 40; t++) begin
            step(1'b0);
            if (acc_last[i]) break;
        end
        check("accept_timeout", i, {7'b0, acc_last[i]}, 8'd1);
    endtask

    initial begin
        logic r;
        cyc      = 0;
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 2; i++) begin
            vld[i]      = 1'b0;
            code[i]     = '0;
            par_bad[i]  = 1'b0;
            acc_last[i] = 1'b0;
        end
        m_reset();

        // Reset held two cycles, then idle
        step(1'b1);
        step(1'b1);
        idle(2);

        // Single code 5 on HOLD=4/GAP=1
        send(0, 5, 1'b0);
        idle(7);

        // Back-to-back 0, 7, 2 with buffer back-pressure
        send(0, 0, 1'b0);
        send(0, 7, 1'b0);
        send(0, 2, 1'b0);
        idle(16);

        // HOLD=1/GAP=0 stream 1, 2, 3 with no gaps
        send(1, 1, 1'b0);
        send(1, 2, 1'b0);
        send(1, 3, 1'b0);
        idle(4);

        // Reset during strobe of 6 with 4 buffered
        send(0, 6, 1'b0);
        send(0, 4, 1'b0);
        vld[0] = 1'b0;
        step(1'b0);
        step(1'b1);
        idle(12);

`ifdef DECODER_STROBE_PARITY_EN
        // Bad parity is consumed without decoding, then a good resend
        send(0, 3, 1'b1);
        idle(3);
        send(0, 3, 1'b0);
        idle(7);
`endif

        // Randomized traffic on both instances with occasional resets
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!vld[i] || acc_last[i]) begin
                    vld[i]     = ($urandom_range(0, 3) != 0);
                    code[i]    = 3'($urandom_range(0, 7));
                    par_bad[i] = 1'b0;
`ifdef DECODER_STROBE_PARITY_EN
                    par_bad[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end
            r = ($urandom_range(0, 99) == 0);
            step(r);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/decoder_strobe.md
Name: decoder_strobe

Overview:
- Sequential 3-to-8 decoder; the receive-side counterpart of the team's 8-to-3 encoder.
- Takes a 3-bit code {a,b,c} (a = MSB) through a valid/ready handshake.
- Drives the matching one-hot line of d[0:7] for a programmable number of cycles, then an all-zero gap.
- A one-entry buffer lets the next code queue while the current strobe is in progress.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot strobe stays asserted (legal range >= 1)
GAP_CYCLES, 1, all-zero cycles after each strobe (legal range >= 0; 0 means back-to-back strobes)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
a  input  1  code bit 2 (MSB)
b  input  1  code bit 1
c  input  1  code bit 0 (LSB)
in_valid  input  1  code on a/b/c is valid
in_ready  output  1  block can accept a code this cycle
d  output  8  one-hot strobe, declared [0:7]; d[k] high for code k = {a,b,c}
strobe  output  1  high whenever any d bit is high
busy  output  1  high when state != IDLE or the buffer is full

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: d=8'b0, strobe=0, busy=0, state=IDLE, buffer empty, counter=0. This makes in_ready=1 on the first cycle after reset.
- Reset mid-operation: rst wins over all other events. The strobe is cut on the next edge and any buffered code is discarded.
- Handshake: a transfer occurs when in_valid && in_ready at a rising edge. in_ready = !buf_full (combinational from the register).
- States:
  - IDLE: d = 0.
    - On transfer, load the code directly: d <= one-hot(code), counter <= HOLD_CYCLES-1, go to DRIVE.
    - The buffer is not used in this case.
  - DRIVE: d holds one-hot(code).
    - Counter decrements each cycle.
    - When counter == 0 and GAP_CYCLES > 0: d <= 0, counter <= GAP_CYCLES-1, go to GAP.
    - When counter == 0 and GAP_CYCLES == 0: take the next code (see "Next-code select"), else go to IDLE.
    - A transfer during DRIVE writes the buffer.
  - GAP: d = 0.
    - Counter decrements each cycle.
    - When counter == 0: take the next code, else go to IDLE.
- Next-code select, at the end of DRIVE or GAP:
  - Buffer full: pop the buffer into d, go to DRIVE. The buffer becomes empty and in_ready rises next cycle.
  - Buffer empty and a transfer occurs this same cycle: load the input directly into d, go to DRIVE. The buffer is not written.
  - Neither: go to IDLE with d = 0.
- Latency:
  - A code accepted in IDLE at edge T appears on d after edge T, for exactly HOLD_CYCLES cycles.
  - Period between consecutive strobes is HOLD_CYCLES + GAP_CYCLES.
- Full buffer: in_ready = 0. in_valid is ignored and no code is dropped silently. The upstream block must hold the code until ready.
- strobe = |d, registered consistently with d (same cycle).
- d is always one-hot or zero, never more than one bit set.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1).

Optional Feature:
- Macro: DECODER_STROBE_PARITY_EN.
- When defined:
  - Adds input `par` (1 bit, even parity over {a,b,c,par}) and output `perr` (1 bit, reset 0).
  - A transfer with a parity mismatch is consumed (handshake completes) but not decoded or buffered.
  - perr pulses high for exactly one cycle after that edge. State and d are unaffected.
- When undefined: no par or perr ports. Every transfer is decoded.

Test Plan:
1. Reset then idle (HOLD=4, GAP=1): rst held 2 cycles -> d=0, strobe=0, busy=0, in_ready=1.
2. Single code: {a,b,c}=3'b101 accepted in IDLE at edge T -> d=8'b00000100 (d[5]) for cycles T+1..T+4, d=0 at T+5, busy low from T+6.
3. Back-to-back: codes 0 then 7 presented continuously -> d[0] for 4 cycles, 1 zero cycle, then d[7] for 4 cycles. in_ready drops while the buffer holds 7 and a third code (2) waits until ready. Period is exactly 5 cycles.
4. GAP_CYCLES=0, HOLD=1: stream codes 1,2,3 -> d shows 8'b01000000, 8'b00100000, 8'b00010000 on consecutive cycles with no zero gap.
5. Reset mid-strobe: rst asserted during DRIVE of code 6 with code 4 buffered -> next edge d=0, buffer empty, code 4 never appears.
6. With DECODER_STROBE_PARITY_EN: code 3'b011 sent with par=1 (bad) -> perr=1 for one cycle, d stays 0. Resend with par=0 -> d[3] strobes for HOLD cycles.
